// File: rtl/timer_pkg.sv
// Shared register map, bit indices and state type for the bus timer.
package timer_pkg;

  localparam logic [15:0] DEVICE_ID   = 16'h0300;
  localparam logic [15:0] DEVICE_TYPE = 16'h0004;

  localparam logic [3:0] CTRL_ID     = 4'd0;
  localparam logic [3:0] CTRL_TYPE   = 4'd1;
  localparam logic [3:0] CTRL_FLAGS  = 4'd2;
  localparam logic [3:0] CTRL_STATUS = 4'd3;

  localparam logic [7:0] BANK_PRESCALE = 8'd0;
  localparam logic [7:0] BANK_RELOAD   = 8'd1;
  localparam logic [7:0] BANK_COUNT    = 8'd2;

  localparam int unsigned FLAG_ENABLE      = 0;
  localparam int unsigned FLAG_AUTO_RELOAD = 1;
  localparam int unsigned FLAG_IRQ_EN      = 2;

  localparam int unsigned STAT_EXPIRED = 0;
  localparam int unsigned STAT_RUNNING = 1;

  typedef enum logic {IDLE, RUN} state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator: counts 0..limit while enabled and pulses tick on the wrap cycle.
module timer_prescaler (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;

  // >= so that lowering limit below the current count still wraps promptly
  always_comb begin
    tick  = enable && (cnt_q >= limit);
    cnt_d = '0;
    if (enable && !tick) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_device.sv
// Down-counting bus timer: register file, read decode and count state machine.
// Optional interrupt output and FLAGS.IRQ_EN storage are built when TIMER_IRQ_EN is defined.
module timer_device
  import timer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        control,
  input  logic [7:0]  address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        irq
);

  state_e      state_q, state_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic        auto_q, auto_d;
  logic        expired_q, expired_d;
  logic        running, tick, expire, irq_en;
  logic        flags_wr, status_wr, prescale_wr, reload_wr, count_wr;

  assign running     = (state_q == RUN);
  assign flags_wr    = write_enable && control && (address[3:0] == CTRL_FLAGS);
  assign status_wr   = write_enable && control && (address[3:0] == CTRL_STATUS);
  assign prescale_wr = write_enable && !control && (address == BANK_PRESCALE);
  assign reload_wr   = write_enable && !control && (address == BANK_RELOAD);
  assign count_wr    = write_enable && !control && (address == BANK_COUNT);

  timer_prescaler u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (running),
    .limit  (prescale_q),
    .tick   (tick)
  );

  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    reload_d   = reload_q;
    count_d    = count_q;
    auto_d     = auto_q;
    expired_d  = expired_q;
    expire     = 1'b0;

    // A COUNT write on the same edge drops the tick entirely
    if (running && tick && !count_wr) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else begin
        expire = 1'b1;
        if (auto_q) begin
          count_d = reload_q;
        end else begin
          state_d = IDLE;
        end
      end
    end

    if (prescale_wr) prescale_d = data_in;
    if (reload_wr)   reload_d   = data_in;
    if (count_wr)    count_d    = data_in;
    if (flags_wr) begin
      state_d = data_in[FLAG_ENABLE] ? RUN : IDLE;
      auto_d  = data_in[FLAG_AUTO_RELOAD];
    end

    if (status_wr && data_in[STAT_EXPIRED]) expired_d = 1'b0;
    if (expire) expired_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prescale_q <= '0;
      reload_q   <= '0;
      count_q    <= '0;
      auto_q     <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      auto_q     <= auto_d;
      expired_q  <= expired_d;
    end
  end

`ifdef TIMER_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
    end else if (flags_wr) begin
      irq_en_q <= data_in[FLAG_IRQ_EN];
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = expired_q & irq_en_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    data_out = '0;
    if (control) begin
      case (address[3:0])
        CTRL_ID:     data_out = DEVICE_ID;
        CTRL_TYPE:   data_out = DEVICE_TYPE;
        CTRL_FLAGS:  data_out = {13'd0, irq_en, auto_q, running};
        CTRL_STATUS: data_out = {14'd0, running, expired_q};
        default:     data_out = '0;
      endcase
    end else begin
      case (address)
        BANK_PRESCALE: data_out = prescale_q;
        BANK_RELOAD:   data_out = reload_q;
        BANK_COUNT:    data_out = count_q;
        default:       data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: directed scenarios plus randomized bus traffic
// checked every cycle against a behavioural timer model.
module tb_timer_device;

`ifdef TIMER_IRQ_EN
  localparam bit IrqBuilt = 1'b1;
`else
  localparam bit IrqBuilt = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic        control = 1'b0;
  logic [7:0]  address = 8'd0;
  logic [15:0] data_in = 16'd0;
  logic [15:0] data_out;
  logic        irq;

  int tests = 0;
  int fails = 0;

  timer_device dut (
    .clock        (clock),
    .reset        (reset),
    .write_enable (write_enable),
    .control      (control),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  // Behavioural model state
  logic [15:0] m_prescale = 0, m_reload = 0, m_count = 0, m_pre = 0;
  bit          m_en = 0, m_auto = 0, m_irqen = 0, m_exp = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_prescale = 0; m_reload = 0; m_count = 0; m_pre = 0;
      m_en = 0; m_auto = 0; m_irqen = 0; m_exp = 0;
    end else begin
      bit tick, cwr, expire;
      logic [15:0] next_pre;
      tick     = m_en && (m_pre >= m_prescale);
      next_pre = (m_en && !tick) ? m_pre + 16'd1 : 16'd0;
      cwr      = write_enable && !control && (address == 8'd2);
      expire   = 0;
      if (tick && !cwr) begin
        if (m_count == 0) begin
          expire = 1;
          if (m_auto) m_count = m_reload;
          else m_en = 0;
        end else begin
          m_count = m_count - 16'd1;
        end
      end
      if (write_enable) begin
        if (control) begin
          if (address[3:0] == 4'd2) begin
            m_en    = data_in[0];
            m_auto  = data_in[1];
            m_irqen = IrqBuilt ? data_in[2] : 1'b0;
          end else if (address[3:0] == 4'd3 && data_in[0]) begin
            m_exp = 0;
          end
        end else begin
          case (address)
            8'd0: m_prescale = data_in;
            8'd1: m_reload   = data_in;
            8'd2: m_count    = data_in;
            default: ;
          endcase
        end
      end
      if (expire) m_exp = 1;
      m_pre = next_pre;
    end
  end

  function automatic logic [15:0] model_read(input logic c, input logic [7:0] a);
    if (c) begin
      case (a[3:0])
        4'd0: return 16'h0300;
        4'd1: return 16'h0004;
        4'd2: return {13'd0, m_irqen, m_auto, m_en};
        4'd3: return {14'd0, m_en, m_exp};
        default: return 16'd0;
      endcase
    end
    case (a)
      8'd0: return m_prescale;
      8'd1: return m_reload;
      8'd2: return m_count;
      default: return 16'd0;
    endcase
  endfunction

  function automatic bit model_expiring();
    return m_en && (m_pre >= m_prescale) && (m_count == 0);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge
  always @(negedge clock) begin
    check("data_out vs model", data_out, model_read(control, address));
    check("irq vs model", {15'd0, irq}, {15'd0, m_exp & m_irqen});
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic c, input logic [7:0] a, input logic [15:0] d);
    control = c; address = a; data_in = d; write_enable = 1'b1;
    @(posedge clock);
    #1;
    write_enable = 1'b0;
  endtask

  task automatic rd(input string name, input logic c, input logic [7:0] a,
                    input logic [15:0] exp);
    control = c; address = a;
    #1;
    check(name, data_out, exp);
  endtask

  task automatic poll_expired(input string name, input int exp_edges, input int limit);
    int n = -1;
    control = 1'b1; address = 8'd3;
    for (int i = 1; i <= limit; i++) begin
      sync();
      if (data_out[0]) begin
        n = i;
        break;
      end
    end
    check(name, 16'(n), 16'(exp_edges));
  endtask

  initial begin
    int n;
    bit hit;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    rd("reset id", 1'b1, 8'd0, 16'h0300);
    rd("reset type", 1'b1, 8'd1, 16'h0004);
    rd("reset status", 1'b1, 8'd3, 16'h0000);
    rd("reset bank0", 1'b0, 8'd0, 16'h0000);
    check("reset irq", {15'd0, irq}, 16'd0);

    // One-shot: N=3, P=0 -> expiry 4 edges after enabling write
    sync();
    wr(1'b0, 8'd0, 16'd0);
    wr(1'b0, 8'd2, 16'd3);
    wr(1'b1, 8'd2, 16'd1);
    poll_expired("oneshot edges", 4, 40);
    rd("oneshot flags", 1'b1, 8'd2, 16'h0000);
    rd("oneshot count", 1'b0, 8'd2, 16'h0000);
    rd("oneshot status", 1'b1, 8'd3, 16'h0001);

    // Auto-reload: P=1, RELOAD=2, COUNT=0
    sync();
    wr(1'b1, 8'd3, 16'd1);
    wr(1'b0, 8'd0, 16'd1);
    wr(1'b0, 8'd1, 16'd2);
    wr(1'b0, 8'd2, 16'd0);
    wr(1'b1, 8'd2, 16'd3);
    poll_expired("autoreload edges", 2, 40);
    rd("reload count 2", 1'b0, 8'd2, 16'd2);
    sync(); sync();
    rd("reload count 1", 1'b0, 8'd2, 16'd1);
    sync(); sync();
    rd("reload count 0", 1'b0, 8'd2, 16'd0);
    rd("reload running", 1'b1, 8'd3, 16'h0003);

    // Interrupt and clear
    wr(1'b1, 8'd3, 16'd1);
    wr(1'b1, 8'd2, 16'd7);
    control = 1'b1; address = 8'd3; n = -1;
    for (int i = 1; i <= 20; i++) begin
      sync();
      if (data_out[0]) begin n = i; break; end
    end
    check("irq expiry seen", 16'(n > 0), 16'd1);
    check("irq asserted", {15'd0, irq}, {15'd0, IrqBuilt});
    wr(1'b1, 8'd3, 16'd1);
    check("irq cleared", {15'd0, irq}, 16'd0);
    rd("status cleared", 1'b1, 8'd3, 16'h0002);

    // Clear coinciding with expiry: set wins
    sync();
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      if (model_expiring()) begin
        wr(1'b1, 8'd3, 16'd1);
        hit = 1;
        break;
      end
      sync();
    end
    check("coincide found", 16'(hit), 16'd1);
    rd("coincide status", 1'b1, 8'd3, 16'h0003);
    check("coincide irq", {15'd0, irq}, {15'd0, IrqBuilt});

    // COUNT write on a tick edge: write wins
    sync();
    wr(1'b0, 8'd0, 16'd0);
    wr(1'b0, 8'd2, 16'h0010);
    wr(1'b0, 8'd2, 16'h00FF);
    rd("count write wins", 1'b0, 8'd2, 16'h00FF);
    sync();
    rd("count after tick", 1'b0, 8'd2, 16'h00FE);

    // Reset mid-count
    sync();
    wr(1'b1, 8'd2, 16'd0);
    wr(1'b0, 8'd0, 16'd3);
    wr(1'b0, 8'd1, 16'd5);
    wr(1'b0, 8'd2, 16'd10);
    wr(1'b1, 8'd2, 16'd5);
    repeat (3) sync();
    reset = 1'b1;
    rd("rst prescale", 1'b0, 8'd0, 16'd0);
    rd("rst reload", 1'b0, 8'd1, 16'd0);
    rd("rst count", 1'b0, 8'd2, 16'd0);
    rd("rst flags", 1'b1, 8'd2, 16'd0);
    rd("rst status", 1'b1, 8'd3, 16'd0);
    check("rst irq", {15'd0, irq}, 16'd0);
    sync();
    reset = 1'b0;
    repeat (60) sync();
    rd("no expiry after reset", 1'b1, 8'd3, 16'd0);

    // Randomized traffic, checked by the compare process every cycle
    sync();
    for (int i = 0; i < 3000; i++) begin
      control = 1'($urandom_range(0, 1));
      if (control) begin
        address = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 5))};
        if ($urandom_range(0, 3) != 0) address[7:4] = 4'd0;
      end else begin
        address = 8'($urandom_range(0, 4));
      end
      write_enable = ($urandom_range(0, 3) == 0);
      data_in = ($urandom_range(0, 31) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
      if (control && address[3:0] == 4'd2 && $urandom_range(0, 2) != 0) data_in[0] = 1'b1;
      if (i == 1500) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
      @(posedge clock);
      #1;
    end
    write_enable = 1'b0;
    repeat (2) sync();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timer_device.md
# timer_device

Programmable down-counting timer on the processor device bus, instanced beside the UART by the device bus dispatcher. The dispatcher decodes target device and drives write enable. This block decodes the register offset, services the write, and returns read data. Supports a prescaler, one-shot or auto-reload modes, a sticky expiry flag and an optional interrupt.

## Interface
- DEVICE_ID, 16'h0300, value returned at control offset 0
- DEVICE_TYPE, 16'h0004, value returned at control offset 1
- clock  input  1  sole clock, CPU clock domain
- reset  input  1  asynchronous, active-high
- write_enable  input  1  write strobe, already qualified by the dispatcher for this device
- control  input  1  1 = control-block access, 0 = bank access
- address  input  8  register offset within the selected space
- data_in  input  16  write data
- data_out  output  16  read data for the current address
- irq  output  1  interrupt request, level

## Operation
- Control space (control=1, address[3:0]):
  - 0: DEVICE_ID, read-only.
  - 1: DEVICE_TYPE, read-only.
  - 2: FLAGS, read/write. bit0 ENABLE, bit1 AUTO_RELOAD, bit2 IRQ_EN, others read 0.
  - 3: STATUS. bit0 EXPIRED is sticky, write 1 to clear. bit1 RUNNING is read-only.
- Control space offsets 4-15 read 0. Writes to them are ignored.
- Bank space (control=0, address[7:0]):
  - 0: PRESCALE, read/write.
  - 1: RELOAD, read/write.
  - 2: COUNT. Reads return the live count. Writes load it.
  - Other offsets read 0. Writes to them are ignored.
- States:
  - IDLE: ENABLE=0.
  - RUN: ENABLE=1. The prescaler counts 0..PRESCALE and emits one tick on the cycle it wraps. PRESCALE=0 means a tick every cycle.
  - In RUN, each tick with COUNT≠0 decrements COUNT.
  - In RUN, a tick with COUNT=0 sets EXPIRED. Then, if AUTO_RELOAD=1, COUNT←RELOAD and stay in RUN. If AUTO_RELOAD=0, hardware clears ENABLE and the block goes to IDLE.
- RUNNING = (state==RUN).
- Clearing ENABLE by a write: COUNT freezes and the prescaler clears to 0. Re-enabling resumes from the frozen COUNT.
- Simultaneous events:
  - A COUNT write and a tick in the same cycle: the write wins. The tick is dropped.
  - A STATUS write-1 clear and a new expiry in the same cycle: the set wins, EXPIRED stays 1.
  - A FLAGS write and a one-shot hardware clear of ENABLE in the same cycle: the written value wins.
- Arithmetic: all registers are 16-bit unsigned. COUNT never wraps below 0, because expiry happens at 0.
- irq = EXPIRED & IRQ_EN, with TIMER_IRQ_EN defined.

## Timing
- Reset values:
  - All registers, prescaler and state are 0, state IDLE.
  - data_out reflects the current address decode: with address 0 in control space it reads DEVICE_ID, in bank space it reads 0.
  - irq = 0.
- data_out is a combinational decode of control and address over registered state, with no added latency. The dispatcher's output register supplies the bus's single cycle of read latency.
- Writes take effect on the clock edge where write_enable=1. The new value is visible on data_out in the following cycle.
- Expiry latency:
  - Tick to EXPIRED set: 1 edge.
  - EXPIRED to irq: combinational.
  - One-shot enable with COUNT=N and PRESCALE=P: EXPIRED sets (N+1)·(P+1) edges after the enabling write.
- Asynchronous reset mid-count abandons the count immediately. No tick or expiry follows reset release until ENABLE is rewritten.

## Configuration
- TIMER_IRQ_EN defined:
  - irq is driven as above.
  - FLAGS bit2 is implemented.
- TIMER_IRQ_EN undefined:
  - irq is tied 0.
  - FLAGS bit2 is not stored and reads 0.
  - EXPIRED polling is unaffected.

## Structure
- Package timer_pkg holds:
  - Control offsets (CTRL_ID, CTRL_TYPE, CTRL_FLAGS, CTRL_STATUS).
  - Bank offsets (BANK_PRESCALE, BANK_RELOAD, BANK_COUNT).
  - FLAGS/STATUS bit indices.
  - The state enum {IDLE, RUN}.
- One sub-module, timer_prescaler: inputs clock, reset, enable and 16-bit limit; output tick. It clears when enable=0.
- Register file, read mux and count state machine stay in timer_device.

## Test plan
- Reset, then read control 0 and 1: data_out=16'h0300 and 16'h0004. Read STATUS: 0. irq=0.
- PRESCALE=0, COUNT=3, FLAGS=1 (one-shot): EXPIRED sets exactly 4 edges after the FLAGS write. FLAGS reads 0 afterward. COUNT holds at 0.
- PRESCALE=1, RELOAD=2, COUNT=0, FLAGS=3 (auto-reload): EXPIRED at edge 2. COUNT then reads 2, 1, 0 at 2-cycle spacing. RUNNING stays 1.
- With IRQ_EN=1 and TIMER_IRQ_EN defined, let the timer expire: irq=1. Write STATUS=1: irq=0 on the next cycle. Repeat with the clear coinciding with an expiry: EXPIRED stays 1.
- COUNT write of 16'h00FF on the same edge as a tick: COUNT reads 16'h00FF, not 16'h00FE.
- Assert reset mid-count with COUNT=10: all registers read 0 and irq=0 immediately. No expiry follows release.
